sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Raster-to-window front end for the `sobel` edge core. Accepts an 8-bit grayscale pixel stream in row-major order, buffers two previous image rows, and presents each complete 3x3 neighbourhood as the eight 9-bit neighbour buses `p0..p3`, `p5..p8` that `sobel` consumes. The centre pixel is not needed by `sobel` and is not output. Only interior centres are emitted; border pixels never produce a window.

## Interface
- `IMG_W`, default 64: image width in pixels. Must be ≥ 3.
- `IMG_H`, default 64: image height in rows. Must be ≥ 3.
- `clk` input, 1 bit: the single clock. All logic is rising-edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: `in_pixel` is accepted on this cycle. There is no backpressure.
- `in_sof` input, 1 bit: start of frame. Only meaningful when `in_valid` = 1.
- `in_pixel` input, 8 bits: unsigned pixel value.
- `p0`, `p1`, `p2` output, 9 bits each: top row of the window (y−1), left to right.
- `p3`, `p5` output, 9 bits each: middle row (y), left and right of centre.
- `p6`, `p7`, `p8` output, 9 bits each: bottom row (y+1), left to right.
- `win_valid` output, 1 bit: the `p*` outputs hold a new window this cycle.
- `eof` output, 1 bit: one-cycle pulse; the last pixel of a frame was accepted.

## Operation
- Internal counters:
  - column `x`, range 0..IMG_W−1.
  - row `y`, range 0..IMG_H−1.
- On each accepted pixel, with `in_sof` = 0:
  - The pixel is at position (x, y).
  - After the update, x increments.
  - When x reaches IMG_W−1, x wraps to 0 and y increments.
  - When y reaches IMG_H−1, y wraps to 0 and the next frame begins automatically.
- On an accepted pixel with `in_sof` = 1:
  - The pixel is taken as (0, 0) regardless of the counter values.
  - After it, the counters become x = 1, y = 0.
  - The partial previous frame is abandoned; no window from it is emitted after this cycle.
- `in_sof` with `in_valid` = 0 is ignored.
- Storage:
  - Line buffer A holds row y−1.
  - Line buffer B holds row y−2.
  - Each is IMG_W × 8 bits, indexed by x.
  - On accept: read A[x] and B[x], write B[x] ← A[x] and A[x] ← `in_pixel`.
- Window columns:
  - A 3-column shift register of (B[x], A[x], `in_pixel`) triples shifts only on accepted pixels.
  - Column x−2 maps to `p0`/`p3`/`p6`, column x−1 to `p1`/—/`p7`, column x to `p2`/`p5`/`p8`.
  - The middle row of column x−1 (the centre) is dropped.
- Window condition: an accepted pixel at (x, y) with x ≥ 2 and y ≥ 2 completes the window whose centre is (x−1, y−1).
- Every `p*` output is zero-extended: bit 8 = 0.
- Stale line-buffer data from a previous frame, or from before reset, never reaches a valid window. The y ≥ 2 gate guarantees this.
- Window count per full frame is (IMG_W−2)·(IMG_H−2).

## Timing
- Latency: `win_valid` and the `p*` values are registered and appear exactly 1 cycle after the accepting edge of the completing pixel.
- `win_valid` is high for one cycle per window.
- `p*` outputs hold their last value while `win_valid` = 0.
- Gaps (`in_valid` = 0) freeze all state. Window content is independent of gap pattern.
- `eof` pulses 1 cycle after acceptance of pixel (IMG_W−1, IMG_H−1). In that same cycle, `win_valid` = 1 for the last window.
- Reset values:
  - Outputs: all `p*` = 0, `win_valid` = 0, `eof` = 0.
  - Counters: x = 0, y = 0; the column registers are cleared.
  - Line-buffer contents are don't-care.
- `rst` asserted with `in_valid` = 1: reset wins and the pixel is discarded. The next accepted pixel is (0, 0).
- Line-buffer read and write at the same address in the same cycle must return the old value. This is read-before-write and is required for correctness.

## Test plan
- IMG_W = 4, IMG_H = 4, pixel = 16·y + x, continuous `in_valid`:
  - Exactly 4 `win_valid` pulses.
  - First window: `p0`=0, `p1`=1, `p2`=2, `p3`=16, `p5`=18, `p6`=32, `p7`=33, `p8`=34.
  - Last window: `p0`=17, `p1`=18, `p2`=19, `p3`=33, `p5`=35, `p6`=49, `p7`=50, `p8`=51.
  - `eof` coincides with the last `win_valid`.
- Same frame with random `in_valid` gaps of 0–5 cycles → identical window sequence. `win_valid` always appears 1 cycle after the completing accept.
- Two back-to-back frames, the second with pixel = 255 − (16·y + x):
  - 8 windows total.
  - Second frame first window: `p0`=255, `p8`=221.
  - No window mixes data from the two frames.
- `in_sof` = 1 on pixel (2, 2) of a frame:
  - No further window from the old frame.
  - Counters restart; the first new window appears after 2·IMG_W + 3 accepts counted from the `in_sof` pixel.
- `rst` asserted mid-row of row 3 → all outputs 0 next cycle. Restreamed full frame yields the same 4 windows as the first scenario.
- `sobel_window_gen` + `sobel`, IMG_W = IMG_H = 5, vertical step edge (x < 2 → 0, else 200): expected `sobel` magnitude 255 (saturated) at centres x = 1 and x = 2, and 0 at x = 3.

Source files
------------

// File: rtl/sobel_window_gen.sv
// Raster-to-window front end for the sobel edge core: buffers two prior rows
// and emits each interior 3x3 neighbourhood (centre omitted) one cycle after it completes.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic [8:0] p0,
  output logic [8:0] p1,
  output logic [8:0] p2,
  output logic [8:0] p3,
  output logic [8:0] p5,
  output logic [8:0] p6,
  output logic [8:0] p7,
  output logic [8:0] p8,
  output logic       win_valid,
  output logic       eof
);

  localparam int DATA_W = 8;
  localparam int XW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int YW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [DATA_W-1:0] r_lb_a [IMG_W];
  logic [DATA_W-1:0] r_lb_b [IMG_W];

  logic [DATA_W-1:0] r_c1_top, r_c1_mid, r_c1_bot;
  logic [DATA_W-1:0] r_c2_top, r_c2_mid, r_c2_bot;

  logic [DATA_W-1:0] r_t0_p1, r_t1_p1, r_t2_p1;
  logic [DATA_W-1:0] r_ml_p1, r_mr_p1;
  logic [DATA_W-1:0] r_b0_p1, r_b1_p1, r_b2_p1;
  logic              r_vld_p1;
  logic              r_eof_p1;

  logic [XW-1:0]     w_x;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_acc;
  logic              w_win;
  logic              w_last;

  // Stage p0: an in_sof pixel is forced to column 0 before addressing the line buffers
  assign w_acc  = in_valid && !rst;
  assign w_x    = in_sof ? '0 : r_x;
  assign w_a    = r_lb_a[w_x];
  assign w_b    = r_lb_b[w_x];
  assign w_win  = in_valid && !in_sof && (r_x >= X_TWO) && (r_y >= Y_TWO);
  assign w_last = in_valid && !in_sof && (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (in_valid) begin
      if (in_sof) begin
        r_x <= XW'(1);
        r_y <= '0;
      end else if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Async read above plus clocked write here gives read-before-write on a shared address
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb_b[w_x] <= w_a;
      r_lb_a[w_x] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c1_top <= '0;
      r_c1_mid <= '0;
      r_c1_bot <= '0;
      r_c2_top <= '0;
      r_c2_mid <= '0;
      r_c2_bot <= '0;
    end else if (in_valid) begin
      r_c2_top <= r_c1_top;
      r_c2_mid <= r_c1_mid;
      r_c2_bot <= r_c1_bot;
      r_c1_top <= w_b;
      r_c1_mid <= w_a;
      r_c1_bot <= in_pixel;
    end
  end

  // Stage p1: registered window, held between valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_eof_p1 <= 1'b0;
      r_t0_p1  <= '0;
      r_t1_p1  <= '0;
      r_t2_p1  <= '0;
      r_ml_p1  <= '0;
      r_mr_p1  <= '0;
      r_b0_p1  <= '0;
      r_b1_p1  <= '0;
      r_b2_p1  <= '0;
    end else begin
      r_vld_p1 <= w_win;
      r_eof_p1 <= w_last;
      if (w_win) begin
        r_t0_p1 <= r_c2_top;
        r_t1_p1 <= r_c1_top;
        r_t2_p1 <= w_b;
        r_ml_p1 <= r_c2_mid;
        r_mr_p1 <= w_a;
        r_b0_p1 <= r_c2_bot;
        r_b1_p1 <= r_c1_bot;
        r_b2_p1 <= in_pixel;
      end
    end
  end

  assign p0        = {1'b0, r_t0_p1};
  assign p1        = {1'b0, r_t1_p1};
  assign p2        = {1'b0, r_t2_p1};
  assign p3        = {1'b0, r_ml_p1};
  assign p5        = {1'b0, r_mr_p1};
  assign p6        = {1'b0, r_b0_p1};
  assign p7        = {1'b0, r_b1_p1};
  assign p8        = {1'b0, r_b2_p1};
  assign win_valid = r_vld_p1;
  assign eof       = r_eof_p1;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: image-level model pushes expected windows,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic [8:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic       win_valid, eof;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .win_valid(win_valid), .eof(eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  logic [7:0]  img [H][W];
  logic [71:0] exp_win [$];
  int          exp_cyc [$];
  int          exp_eof [$];
  bit          done = 1'b0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [71:0] window_at(input int x, input int y);
    return {1'b0, img[y-2][x-2], 1'b0, img[y-2][x-1], 1'b0, img[y-2][x],
            1'b0, img[y-1][x-2], 1'b0, img[y-1][x],
            1'b0, img[y][x-2], 1'b0, img[y][x-1], 1'b0, img[y][x]};
  endfunction

  task automatic fill_ramp(input bit invert);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = invert ? 8'(255 - (16*y + x)) : 8'(16*y + x);
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = 8'($urandom_range(0, 255));
  endtask

  // Streams the first n pixels of img in raster order; a window is due for every
  // pixel whose full 3x3 neighbourhood above-left is inside the frame.
  task automatic run_frame(input int n, input bit sof_first, input int maxgap);
    for (int k = 0; k < n; k++) begin
      int x, y;
      x = k % W;
      y = k / W;
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_sof   = sof_first && (k == 0);
      in_pixel = img[y][x];
      if (x >= 2 && y >= 2) begin
        exp_win.push_back(window_at(x, y));
        exp_cyc.push_back(cyc + 1);
      end
      if (k == W*H - 1) exp_eof.push_back(cyc + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  logic [71:0] got;
  logic [71:0] last_got = '0;
  logic [71:0] ew;
  int          ec;

  always @(negedge clk) begin
    got = {p0, p1, p2, p3, p5, p6, p7, p8};
    if (rst_q) begin
      tests++;
      if (got !== 72'd0 || win_valid !== 1'b0 || eof !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: got p=%h vld=%b eof=%b, required all zero", got, win_valid, eof);
      end
      last_got = '0;
    end else if (win_valid === 1'b1) begin
      tests++;
      if (exp_win.size() == 0) begin
        fails++;
        $display("FAIL unexpected_window at cycle %0d: got %h, required none", cyc, got);
      end else begin
        ew = exp_win.pop_front();
        ec = exp_cyc.pop_front();
        if (got !== ew || ec != cyc) begin
          fails++;
          $display("FAIL window: got %h at cycle %0d, required %h at cycle %0d", got, cyc, ew, ec);
        end
      end
      last_got = got;
    end else begin
      tests++;
      if (got !== last_got) begin
        fails++;
        $display("FAIL hold: got %h, required %h while win_valid=0", got, last_got);
      end
      if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_window: got no win_valid at cycle %0d, required %h", cyc, exp_win[0]);
        void'(exp_win.pop_front());
        void'(exp_cyc.pop_front());
      end
    end

    if (!rst_q && eof === 1'b1) begin
      tests++;
      if (exp_eof.size() == 0) begin
        fails++;
        $display("FAIL unexpected_eof at cycle %0d", cyc);
      end else begin
        ec = exp_eof.pop_front();
        if (ec != cyc || win_valid !== 1'b1) begin
          fails++;
          $display("FAIL eof: got cycle %0d vld=%b, required cycle %0d vld=1", cyc, win_valid, ec);
        end
      end
    end else if (exp_eof.size() > 0 && exp_eof[0] <= cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_eof: got none at cycle %0d, required at cycle %0d", cyc, exp_eof[0]);
      void'(exp_eof.pop_front());
    end

    if (done) begin
      tests++;
      if (exp_win.size() != 0 || exp_eof.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d windows / %0d eofs outstanding, required 0", exp_win.size(), exp_eof.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    fill_ramp(1'b0);
    run_frame(W*H, 1'b0, 0);

    run_frame(W*H, 1'b0, 5);

    run_frame(W*H, 1'b0, 0);
    fill_ramp(1'b1);
    run_frame(W*H, 1'b0, 0);

    fill_random();
    run_frame(2*W + 2, 1'b0, 0);
    fill_random();
    run_frame(W*H, 1'b1, 2);

    fill_ramp(1'b0);
    run_frame(3*W + 2, 1'b0, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'd99;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    run_frame(W*H, 1'b0, 0);

    for (int f = 0; f < 8; f++) begin
      fill_random();
      if ($urandom_range(0, 1) == 1) begin
        run_frame($urandom_range(1, W*H - 1), 1'b0, 3);
        fill_random();
        run_frame(W*H, 1'b1, 3);
      end else begin
        run_frame(W*H, 1'b0, 3);
      end
    end

    repeat (4) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
